// File: rtl/robo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : robo_pkg
// Description : Shared cell/orientation codes, map geometry, reset pose and
//               controller state encoding for the maze robot.
// Revision    : 1.0 - initial release
// ============================================================================
package robo_pkg;

    localparam int MAP_ROWS = 10;
    localparam int MAP_COLS = 20;

    localparam logic [1:0] CELL_FREE   = 2'd0;
    localparam logic [1:0] CELL_WALL   = 2'd1;
    localparam logic [1:0] CELL_RUBBLE = 2'd2;
    localparam logic [1:0] CELL_EXIT   = 2'd3;

    localparam logic [1:0] ORI_N = 2'd0;
    localparam logic [1:0] ORI_E = 2'd1;
    localparam logic [1:0] ORI_S = 2'd2;
    localparam logic [1:0] ORI_W = 2'd3;

    localparam logic [4:0] RESET_ROW = 5'd8;
    localparam logic [5:0] RESET_COL = 6'd1;
    localparam logic [1:0] RESET_ORI = ORI_N;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FWD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic signed [6:0] delta_row(input logic [1:0] ori);
        case (ori)
            ORI_N:   return -7'sd1;
            ORI_S:   return 7'sd1;
            default: return 7'sd0;
        endcase
    endfunction

    function automatic logic signed [6:0] delta_col(input logic [1:0] ori);
        case (ori)
            ORI_E:   return 7'sd1;
            ORI_W:   return -7'sd1;
            default: return 7'sd0;
        endcase
    endfunction

    function automatic logic [1:0] init_cell(input int r, input int c);
        if (r == 0 || r == MAP_ROWS - 1 || c == 0 || c == MAP_COLS - 1) return CELL_WALL;
        if (r == 1 && c == 5)  return CELL_RUBBLE;
        if (r == 1 && c == 18) return CELL_EXIT;
        return CELL_FREE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/robo_memo.sv
`default_nettype none
// ============================================================================
// Module      : robo_memo
// Description : Map memory, robot pose registers and neighbour sensors.
// Revision    : 1.0 - initial release
// ============================================================================
module robo_memo
    import robo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_turn_left,
    input  logic i_turn_right,
    input  logic i_forward,
    input  logic i_clear_front,
    output logic o_head,
    output logic o_left,
    output logic o_under,
    output logic o_barrier
);

    logic [1:0] map [0:MAP_ROWS-1][0:MAP_COLS-1];
    logic [4:0] robo_row;
    logic [5:0] robo_col;
    logic [1:0] robo_orientacao;

    logic signed [6:0] w_cur_r;
    logic signed [6:0] w_cur_c;
    logic signed [6:0] w_front_r;
    logic signed [6:0] w_front_c;
    logic signed [6:0] w_left_r;
    logic signed [6:0] w_left_c;
    logic [1:0]        w_left_ori;
    logic              w_front_in;
    logic [1:0]        w_front_cell;
    logic [1:0]        w_left_cell;
    logic [1:0]        w_cur_cell;

    // Anything off the map reads as wall so the robot can never step out.
    function automatic logic [1:0] cell_at(input logic signed [6:0] r, input logic signed [6:0] c);
        if (r < 7'sd0 || r >= 7'(MAP_ROWS) || c < 7'sd0 || c >= 7'(MAP_COLS)) return CELL_WALL;
        return map[r[3:0]][c[4:0]];
    endfunction

    always_comb begin
        w_cur_r      = $signed({2'b00, robo_row});
        w_cur_c      = $signed({1'b0, robo_col});
        w_left_ori   = robo_orientacao - 2'd1;
        w_front_r    = w_cur_r + delta_row(robo_orientacao);
        w_front_c    = w_cur_c + delta_col(robo_orientacao);
        w_left_r     = w_cur_r + delta_row(w_left_ori);
        w_left_c     = w_cur_c + delta_col(w_left_ori);
        w_front_in   = (w_front_r >= 7'sd0) && (w_front_r < 7'(MAP_ROWS)) &&
                       (w_front_c >= 7'sd0) && (w_front_c < 7'(MAP_COLS));
        w_front_cell = cell_at(w_front_r, w_front_c);
        w_left_cell  = cell_at(w_left_r, w_left_c);
        w_cur_cell   = cell_at(w_cur_r, w_cur_c);
    end

    assign o_head    = (w_front_cell == CELL_WALL) || (w_front_cell == CELL_RUBBLE);
    assign o_barrier = (w_front_cell == CELL_RUBBLE);
    assign o_left    = (w_left_cell == CELL_WALL) || (w_left_cell == CELL_RUBBLE);
    assign o_under   = (w_cur_cell == CELL_EXIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < MAP_ROWS; r++) begin
                for (int c = 0; c < MAP_COLS; c++) begin
                    map[r][c] <= init_cell(r, c);
                end
            end
            robo_row        <= RESET_ROW;
            robo_col        <= RESET_COL;
            robo_orientacao <= RESET_ORI;
        end else begin
            if (i_clear_front && w_front_in) begin
                map[w_front_r[3:0]][w_front_c[4:0]] <= CELL_FREE;
            end
            if (i_turn_left) begin
                robo_orientacao <= robo_orientacao - 2'd1;
            end else if (i_turn_right) begin
                robo_orientacao <= robo_orientacao + 2'd1;
            end else if (i_forward) begin
                robo_row <= w_front_r[4:0];
                robo_col <= w_front_c[5:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/robo_top.sv
`default_nettype none
// ============================================================================
// Module      : robo_top
// Description : Left-hand wall-following controller driving the maze robot.
// Revision    : 1.0 - initial release
// ============================================================================
module robo_top
    import robo_pkg::*;
(
    input  logic clk,
    input  logic reset
);

    logic   head;
    logic   left;
    logic   under;
    logic   barrier;
    state_t r_state;
    state_t w_state_next;
    logic   w_turn_left;
    logic   w_turn_right;
    logic   w_forward;
    logic   w_clear_front;

    robo_memo memo_inst (
        .clk           (clk),
        .rst           (reset),
        .i_turn_left   (w_turn_left),
        .i_turn_right  (w_turn_right),
        .i_forward     (w_forward),
        .i_clear_front (w_clear_front),
        .o_head        (head),
        .o_left        (left),
        .o_under       (under),
        .o_barrier     (barrier)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FWD skips the left-hand check so a left turn is always followed by a step attempt.
    always_comb begin
        w_state_next = r_state;
        if (r_state != ST_DONE) begin
            if (under) begin
                w_state_next = ST_DONE;
            end else if (r_state == ST_RUN && !left) begin
                w_state_next = ST_FWD;
            end else if (head && barrier) begin
                w_state_next = r_state;
            end else begin
                w_state_next = ST_RUN;
            end
        end
    end

    always_comb begin
        w_turn_left   = 1'b0;
        w_turn_right  = 1'b0;
        w_forward     = 1'b0;
        w_clear_front = 1'b0;
        if (r_state != ST_DONE && !under) begin
            if (r_state == ST_RUN && !left) begin
                w_turn_left = 1'b1;
            end else if (head && barrier) begin
                w_clear_front = 1'b1;
            end else if (head) begin
                w_turn_right = 1'b1;
            end else begin
                w_forward = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_robo_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_robo_top
// Description : Directed trajectory table plus reset and left-turn sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_robo_top;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;
    int step;

    typedef struct {
        int         step;
        logic [4:0] row;
        logic [5:0] col;
        logic [1:0] ori;
        logic       head;
        logic       left;
        logic       under;
        logic       barrier;
        logic [1:0] map15;
    } vec_t;

    vec_t tbl [10];

    robo_top dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pose_vec();
        return {9'd0, dut.memo_inst.robo_row, dut.memo_inst.robo_col,
                dut.memo_inst.robo_orientacao, dut.head, dut.left,
                dut.under, dut.barrier, dut.memo_inst.map[1][5]};
    endfunction

    function automatic logic [31:0] exp_vec(input vec_t v);
        return {9'd0, v.row, v.col, v.ori, v.head, v.left, v.under, v.barrier, v.map15};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        step++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        step  = 0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            while (step < tbl[i].step) tick();
            check($sformatf("%s_step%0d", tag, tbl[i].step), pose_vec(), exp_vec(tbl[i]));
        end
    endtask

    initial begin
        int bad;
        logic [1:0] exp_cell;

        n_tests = 0;
        n_fail  = 0;
        step    = 0;
        reset   = 1'b1;

        //             step row    col    ori  hd  lf  un  br  map15
        tbl[0] = '{ 0,  5'd8, 6'd1,  2'd0, 0, 1, 0, 0, 2'd2};
        tbl[1] = '{ 4,  5'd4, 6'd1,  2'd0, 0, 1, 0, 0, 2'd2};
        tbl[2] = '{ 7,  5'd1, 6'd1,  2'd0, 1, 1, 0, 0, 2'd2};
        tbl[3] = '{ 8,  5'd1, 6'd1,  2'd1, 0, 1, 0, 0, 2'd2};
        tbl[4] = '{11,  5'd1, 6'd4,  2'd1, 1, 1, 0, 1, 2'd2};
        tbl[5] = '{12,  5'd1, 6'd4,  2'd1, 0, 1, 0, 0, 2'd0};
        tbl[6] = '{13,  5'd1, 6'd5,  2'd1, 0, 1, 0, 0, 2'd0};
        tbl[7] = '{26,  5'd1, 6'd18, 2'd1, 1, 1, 1, 0, 2'd0};
        tbl[8] = '{27,  5'd1, 6'd18, 2'd1, 1, 1, 1, 0, 2'd0};
        tbl[9] = '{80,  5'd1, 6'd18, 2'd1, 1, 1, 1, 0, 2'd0};

        do_reset();

        // Full map layout after reset, against an independent rule.
        bad = 0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 20; c++) begin
                if (r == 0 || r == 9 || c == 0 || c == 19) exp_cell = 2'd1;
                else if (r == 1 && c == 5)                 exp_cell = 2'd2;
                else if (r == 1 && c == 18)                exp_cell = 2'd3;
                else                                       exp_cell = 2'd0;
                if (dut.memo_inst.map[r][c] !== exp_cell) bad++;
            end
        end
        check("reset_map", bad, 0);
        check("reset_state", {30'd0, dut.r_state}, 32'd0);

        release_reset();
        run_table("run1");

        // Reset from DONE, then reset mid-run at (4,1,0).
        do_reset();
        check("reset_from_done", pose_vec(), exp_vec(tbl[0]));
        release_reset();
        while (step < 4) tick();
        check("midrun_pose", pose_vec(), exp_vec(tbl[1]));
        reset = 1'b1;
        tick();
        check("midrun_reset", pose_vec(), exp_vec(tbl[0]));
        check("midrun_map15", {30'd0, dut.memo_inst.map[1][5]}, 32'd2);
        release_reset();
        run_table("run2");

        // Left-turn rule: open the wall west of the start cell.
        do_reset();
        release_reset();
        dut.memo_inst.map[8][0] = 2'd0;
        #1;
        check("lt_step0", {29'd0, dut.memo_inst.robo_orientacao, dut.left}, {29'd0, 2'd0, 1'b0});
        tick();
        check("lt_step1", {16'd0, dut.memo_inst.robo_row, dut.memo_inst.robo_col,
                           dut.memo_inst.robo_orientacao, dut.head},
                          {16'd0, 5'd8, 6'd1, 2'd3, 1'b0});
        check("lt_state_fwd", {30'd0, dut.r_state}, 32'd1);
        tick();
        check("lt_step2", {16'd0, dut.memo_inst.robo_row, dut.memo_inst.robo_col,
                           dut.memo_inst.robo_orientacao, dut.head},
                          {16'd0, 5'd8, 6'd0, 2'd3, 1'b1});
        tick();
        check("lt_step3", {16'd0, dut.memo_inst.robo_row, dut.memo_inst.robo_col,
                           dut.memo_inst.robo_orientacao, dut.head},
                          {16'd0, 5'd8, 6'd0, 2'd0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
